fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Controls the instruction-fetch stage: generates its freeze, branch-taken and branch-address inputs, plus pipeline flush and bubble controls.
- Arbitrates four request sources into one PC-update decision per cycle: execute-stage redirects, load-use hazards, memory stalls, and halt/resume.
- Sits between the hazard/execute logic and the fetch stage, and holds a redirect that arrives while fetch cannot load.

Parameters:
DATA_WIDTH, 27, width of PC/branch address
BOOT_CYCLES, 4, cycles fetch stays frozen after reset release (0 = none)
FLUSH_CYCLES, 2, consecutive cycles o_Flush is held per applied redirect (>=1)
CNT_WIDTH, 16, width of performance counters

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
i_Branch_Taken  in  1  execute-stage redirect request
i_Branch_Address  in  DATA_WIDTH  redirect target
i_Load_Use  in  1  load-use hazard detected in decode
i_Mem_Stall  in  1  memory busy; whole front end must hold
i_Halt  in  1  halt instruction in decode
i_Resume  in  1  leave halt
i_Count_Clear  in  1  synchronous clear of both counters
o_Freeze  out  1  to fetch; 1 = PC holds
o_Branch_Taken  out  1  to fetch PC mux
o_Branch_Address  out  DATA_WIDTH  to fetch PC mux
o_Flush  out  1  invalidate IF/ID and ID/EX
o_Bubble  out  1  insert NOP into ID/EX
o_Halted  out  1  state == HALT
o_Stall_Count  out  CNT_WIDTH  saturating count of stall cycles
o_Redirect_Count  out  CNT_WIDTH  saturating count of applied redirects

Behaviour:
- States: BOOT, RUN, PEND (redirect held), HALT. Registers: state, boot counter, pending address, flush counter, two counters.
- Reset asserted (async):
  - state=BOOT, boot counter=0, pending address=0, flush counter=0, both counters=0.
  - Outputs: o_Freeze=1, all other outputs 0.
- BOOT:
  - o_Freeze=1.
  - The counter increments each cycle; the state moves to RUN after BOOT_CYCLES cycles. With BOOT_CYCLES=0, the first cycle after release is RUN.
  - i_Branch_Taken in BOOT: the address is latched into the pending register and the state goes to PEND when boot completes.
- RUN, priority order:
  1. i_Branch_Taken, i_Mem_Stall=0: apply. o_Branch_Taken=1, o_Branch_Address=i_Branch_Address, o_Freeze=0, all combinational in the same cycle. The flush counter loads FLUSH_CYCLES. i_Load_Use and i_Halt are ignored that cycle (wrong path).
  2. i_Branch_Taken, i_Mem_Stall=1: o_Freeze=1, latch the address, next state PEND.
  3. i_Mem_Stall: o_Freeze=1, o_Bubble=0.
  4. i_Load_Use: o_Freeze=1, o_Bubble=1.
  5. i_Halt: next state HALT. This cycle is unfrozen, so the halt instruction itself advances.
- PEND:
  - o_Freeze=1 while i_Mem_Stall=1.
  - First cycle with i_Mem_Stall=0: apply the held address (as in RUN case 1) and move to RUN.
  - New i_Branch_Taken in PEND is ignored; the older redirect wins.
- HALT:
  - o_Freeze=1, o_Halted=1.
  - i_Branch_Taken (an older branch resolving): apply if no mem stall, else latch and go to PEND; either way leave HALT.
  - Otherwise i_Resume moves to RUN next cycle.
- o_Branch_Taken is 1 only in an apply cycle. o_Branch_Address=0 in all other cycles.
- o_Flush:
  - High whenever the flush counter is non-zero or in an apply cycle. The apply cycle counts as the first of FLUSH_CYCLES cycles.
  - The counter decrements each cycle and does not decrement while i_Mem_Stall=1.
  - A new apply inside the window reloads the counter.
- o_Bubble is forced 0 whenever o_Flush=1.
- Counters:
  - o_Stall_Count +1 per cycle with o_Freeze=1 in RUN or PEND; BOOT and HALT cycles are excluded.
  - o_Redirect_Count +1 per apply cycle.
  - Both saturate at all-ones.
  - i_Count_Clear wins over increment in the same cycle.
- Reset mid-operation discards the pending redirect and flush window immediately.

Decomposition:
- Shared package: state enum, and constants for the state encoding and NOP/flush polarity used by the pipeline registers.
- One natural sub-module, sat_counter (CNT_WIDTH, inc, clr), instantiated twice.

Test Plan:
- Boot: release reset with BOOT_CYCLES=4 -> o_Freeze=1 for exactly 4 cycles, then 0; all counters 0.
- Redirect: in RUN, i_Branch_Taken=1, addr=0x000040 -> same cycle o_Branch_Taken=1, o_Branch_Address=0x40, o_Freeze=0; o_Flush high 2 cycles; o_Redirect_Count=1.
- Redirect under stall: i_Mem_Stall=1 for 3 cycles, branch to 0x0001F0 in stall cycle 1 plus second branch to 0x22 in cycle 2 -> freeze 3 cycles; next cycle applies 0x1F0 only; o_Stall_Count=3.
- Load-use and branch collide: i_Load_Use=1 with i_Branch_Taken=1 -> o_Bubble=0, o_Freeze=0, redirect applied. Load-use alone -> o_Freeze=1, o_Bubble=1.
- Halt/resume: i_Halt pulse -> o_Halted=1 next cycle, freeze held 10 cycles without counting; i_Resume -> RUN. A branch to 0x10 during HALT -> immediate apply, o_Halted=0.
- Saturation/clear/reset: preload o_Stall_Count to 0xFFFF via a long stall -> stays 0xFFFF; i_Count_Clear with stall -> 0. Assert reset while in PEND -> outputs to reset values asynchronously, no redirect after release.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and polarity constants for the fetch sequencer and the
// pipeline registers it steers.
package fetch_sequencer_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    // Active levels seen by the IF/ID and ID/EX registers.
    localparam logic FLUSH_ASSERT  = 1'b1;
    localparam logic BUBBLE_ASSERT = 1'b1;
    localparam logic FREEZE_HOLD   = 1'b1;

endpackage

// File: rtl/fetch_sequencer_sat_counter.sv
// Saturating up-counter with a synchronous clear that beats increment.
module sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_inc,
    input  logic                 i_clr,
    output logic [CNT_WIDTH-1:0] o_count
);

    logic [CNT_WIDTH-1:0] r_count;

    // NOTE: clocked state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage PC-update arbiter: boot freeze, redirects (held across memory
// stalls), load-use bubbles, halt/resume, flush window and perf counters.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH   = 27,
    parameter int BOOT_CYCLES  = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_Branch_Taken,
    input  logic [DATA_WIDTH-1:0] i_Branch_Address,
    input  logic                  i_Load_Use,
    input  logic                  i_Mem_Stall,
    input  logic                  i_Halt,
    input  logic                  i_Resume,
    input  logic                  i_Count_Clear,
    output logic                  o_Freeze,
    output logic                  o_Branch_Taken,
    output logic [DATA_WIDTH-1:0] o_Branch_Address,
    output logic                  o_Flush,
    output logic                  o_Bubble,
    output logic                  o_Halted,
    output logic [CNT_WIDTH-1:0]  o_Stall_Count,
    output logic [CNT_WIDTH-1:0]  o_Redirect_Count
);

    localparam int BOOT_W  = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam int FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [BOOT_W-1:0]  BOOT_LAST    = BOOT_W'((BOOT_CYCLES > 0) ? BOOT_CYCLES - 1 : 0);
    localparam logic [FLUSH_W-1:0] FLUSH_RELOAD = FLUSH_W'(FLUSH_CYCLES - 1);
    localparam state_t             RESET_STATE  = (BOOT_CYCLES == 0) ? ST_RUN : ST_BOOT;

    state_t                r_state;
    logic [BOOT_W-1:0]     r_boot_cnt;
    logic [DATA_WIDTH-1:0] r_pend_addr;
    logic                  r_pend_valid;
    logic [FLUSH_W-1:0]    r_flush_cnt;

    logic                  w_apply;
    logic [DATA_WIDTH-1:0] w_apply_addr;
    logic                  w_freeze;
    logic                  w_bubble_req;
    logic                  w_flush;
    logic                  w_stall_inc;

    // An apply is a redirect reaching the PC mux; PEND replays the held target.
    assign w_apply = ((r_state == ST_RUN)  && i_Branch_Taken && !i_Mem_Stall) ||
                     ((r_state == ST_PEND) && !i_Mem_Stall) ||
                     ((r_state == ST_HALT) && i_Branch_Taken && !i_Mem_Stall);
    assign w_apply_addr = (r_state == ST_PEND) ? r_pend_addr : i_Branch_Address;

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        w_freeze     = 1'b0;
        w_bubble_req = 1'b0;
        case (r_state)
            ST_BOOT: w_freeze = FREEZE_HOLD;
            ST_RUN: begin
                if (i_Branch_Taken) begin
                    w_freeze = i_Mem_Stall;
                end else if (i_Mem_Stall) begin
                    w_freeze = FREEZE_HOLD;
                end else if (i_Load_Use) begin
                    w_freeze     = FREEZE_HOLD;
                    w_bubble_req = BUBBLE_ASSERT;
                end
            end
            ST_PEND: w_freeze = i_Mem_Stall;
            ST_HALT: w_freeze = !w_apply;
            default: w_freeze = FREEZE_HOLD;
        endcase
    end

    assign w_flush     = w_apply || (r_flush_cnt != '0);
    assign w_stall_inc = w_freeze && ((r_state == ST_RUN) || (r_state == ST_PEND));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= RESET_STATE;
            r_boot_cnt   <= '0;
            r_pend_addr  <= '0;
            r_pend_valid <= 1'b0;
            r_flush_cnt  <= '0;
        end else begin
            // The apply cycle is the first flush cycle, so reload one short.
            if (w_apply) begin
                r_flush_cnt <= FLUSH_RELOAD;
            end else if ((r_flush_cnt != '0) && !i_Mem_Stall) begin
                r_flush_cnt <= r_flush_cnt - 1'b1;
            end

            case (r_state)
                ST_BOOT: begin
                    if (i_Branch_Taken && !r_pend_valid) begin
                        r_pend_addr  <= i_Branch_Address;
                        r_pend_valid <= 1'b1;
                    end
                    if (r_boot_cnt == BOOT_LAST) begin
                        r_state <= (i_Branch_Taken || r_pend_valid) ? ST_PEND : ST_RUN;
                    end else begin
                        r_boot_cnt <= r_boot_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (i_Branch_Taken) begin
                        if (i_Mem_Stall) begin
                            r_pend_addr <= i_Branch_Address;
                            r_state     <= ST_PEND;
                        end
                    end else if (!i_Mem_Stall && !i_Load_Use && i_Halt) begin
                        r_state <= ST_HALT;
                    end
                end
                ST_PEND: begin
                    if (!i_Mem_Stall) begin
                        r_pend_valid <= 1'b0;
                        r_state      <= ST_RUN;
                    end
                end
                ST_HALT: begin
                    if (i_Branch_Taken) begin
                        if (i_Mem_Stall) begin
                            r_pend_addr <= i_Branch_Address;
                            r_state     <= ST_PEND;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end else if (i_Resume) begin
                        r_state <= ST_RUN;
                    end
                end
                default: r_state <= RESET_STATE;
            endcase
        end
    end

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_stall_inc),
        .i_clr   (i_Count_Clear),
        .o_count (o_Stall_Count)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_redirect_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_apply),
        .i_clr   (i_Count_Clear),
        .o_count (o_Redirect_Count)
    );

    assign o_Freeze         = w_freeze;
    assign o_Branch_Taken   = w_apply;
    assign o_Branch_Address = w_apply ? w_apply_addr : '0;
    assign o_Flush          = w_flush ? FLUSH_ASSERT : !FLUSH_ASSERT;
    assign o_Bubble         = w_bubble_req && !w_flush;
    assign o_Halted         = (r_state == ST_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed-vector bench for fetch_sequencer with default parameters.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        br = 1'b0;
    logic [26:0] addr = '0;
    logic        lu = 1'b0;
    logic        stall = 1'b0;
    logic        halt = 1'b0;
    logic        resume = 1'b0;
    logic        clr = 1'b0;

    logic        o_freeze;
    logic        o_bt;
    logic [26:0] o_addr;
    logic        o_flush;
    logic        o_bubble;
    logic        o_halted;
    logic [15:0] o_stall_cnt;
    logic [15:0] o_redir_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .i_Branch_Taken   (br),
        .i_Branch_Address (addr),
        .i_Load_Use       (lu),
        .i_Mem_Stall      (stall),
        .i_Halt           (halt),
        .i_Resume         (resume),
        .i_Count_Clear    (clr),
        .o_Freeze         (o_freeze),
        .o_Branch_Taken   (o_bt),
        .o_Branch_Address (o_addr),
        .o_Flush          (o_flush),
        .o_Bubble         (o_bubble),
        .o_Halted         (o_halted),
        .o_Stall_Count    (o_stall_cnt),
        .o_Redirect_Count (o_redir_cnt)
    );

    typedef struct {
        logic        br;
        logic [26:0] addr;
        logic        lu, st, ht, rs, cl;
        logic        e_freeze, e_bt;
        logic [26:0] e_addr;
        logic        e_flush, e_bubble, e_halted;
        logic [15:0] e_stall, e_redir;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic b, input logic [26:0] a, input logic l, input logic s,
                                input logic h, input logic r, input logic c,
                                input logic fz, input logic bt, input logic [26:0] ea,
                                input logic fl, input logic bb, input logic hl,
                                input logic [15:0] sc, input logic [15:0] rc);
        vec_t v;
        v.br = b; v.addr = a; v.lu = l; v.st = s; v.ht = h; v.rs = r; v.cl = c;
        v.e_freeze = fz; v.e_bt = bt; v.e_addr = ea; v.e_flush = fl;
        v.e_bubble = bb; v.e_halted = hl; v.e_stall = sc; v.e_redir = rc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic b, input logic [26:0] a, input logic l, input logic s,
                         input logic h, input logic r, input logic c);
        @(negedge clk);
        br = b; addr = a; lu = l; stall = s; halt = h; resume = r; clr = c;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " freeze"},   32'(o_freeze), 32'd1);
        check({tag, " bt"},       32'(o_bt), 32'd0);
        check({tag, " addr"},     32'(o_addr), 32'd0);
        check({tag, " flush"},    32'(o_flush), 32'd0);
        check({tag, " bubble"},   32'(o_bubble), 32'd0);
        check({tag, " halted"},   32'(o_halted), 32'd0);
        check({tag, " stallcnt"}, 32'(o_stall_cnt), 32'd0);
        check({tag, " redircnt"}, 32'(o_redir_cnt), 32'd0);
    endtask

    initial begin
        // br,addr,lu,st,ht,rs,cl | freeze,bt,addr,flush,bubble,halted | stall_cnt,redir_cnt
        for (int i = 0; i < 4; i++)
            vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0,  0, 0));
        vq.push_back(mk(0, 0,      0, 0, 0, 0, 0,  0, 0, 0,      0, 0, 0,  0, 0));
        vq.push_back(mk(1, 'h40,   0, 0, 0, 0, 0,  0, 1, 'h40,   1, 0, 0,  0, 0));
        vq.push_back(mk(0, 0,      0, 0, 0, 0, 0,  0, 0, 0,      1, 0, 0,  0, 1));
        vq.push_back(mk(0, 0,      0, 0, 0, 0, 0,  0, 0, 0,      0, 0, 0,  0, 1));
        vq.push_back(mk(1, 'h1F0,  0, 1, 0, 0, 0,  1, 0, 0,      0, 0, 0,  0, 1));
        vq.push_back(mk(1, 'h22,   0, 1, 0, 0, 0,  1, 0, 0,      0, 0, 0,  1, 1));
        vq.push_back(mk(0, 0,      0, 1, 0, 0, 0,  1, 0, 0,      0, 0, 0,  2, 1));
        vq.push_back(mk(0, 0,      0, 0, 0, 0, 0,  0, 1, 'h1F0,  1, 0, 0,  3, 1));
        vq.push_back(mk(0, 0,      0, 0, 0, 0, 0,  0, 0, 0,      1, 0, 0,  3, 2));
        vq.push_back(mk(1, 'h80,   1, 0, 0, 0, 0,  0, 1, 'h80,   1, 0, 0,  3, 2));
        vq.push_back(mk(0, 0,      1, 0, 0, 0, 0,  1, 0, 0,      1, 0, 0,  3, 3));
        vq.push_back(mk(0, 0,      1, 0, 0, 0, 0,  1, 0, 0,      0, 1, 0,  4, 3));
        vq.push_back(mk(0, 0,      0, 0, 0, 0, 0,  0, 0, 0,      0, 0, 0,  5, 3));
        vq.push_back(mk(1, 'h100,  0, 0, 0, 0, 0,  0, 1, 'h100,  1, 0, 0,  5, 3));
        vq.push_back(mk(0, 0,      0, 1, 0, 0, 0,  1, 0, 0,      1, 0, 0,  5, 4));
        vq.push_back(mk(0, 0,      0, 1, 0, 0, 0,  1, 0, 0,      1, 0, 0,  6, 4));
        vq.push_back(mk(0, 0,      0, 0, 0, 0, 0,  0, 0, 0,      1, 0, 0,  7, 4));
        vq.push_back(mk(0, 0,      0, 0, 0, 0, 0,  0, 0, 0,      0, 0, 0,  7, 4));
        vq.push_back(mk(1, 'h200,  0, 0, 0, 0, 0,  0, 1, 'h200,  1, 0, 0,  7, 4));
        vq.push_back(mk(1, 'h204,  0, 0, 0, 0, 0,  0, 1, 'h204,  1, 0, 0,  7, 5));
        vq.push_back(mk(0, 0,      0, 0, 0, 0, 0,  0, 0, 0,      1, 0, 0,  7, 6));
        vq.push_back(mk(0, 0,      0, 0, 0, 0, 0,  0, 0, 0,      0, 0, 0,  7, 6));
        vq.push_back(mk(0, 0,      0, 0, 1, 0, 0,  0, 0, 0,      0, 0, 0,  7, 6));
        vq.push_back(mk(0, 0,      0, 0, 0, 0, 0,  1, 0, 0,      0, 0, 1,  7, 6));
        vq.push_back(mk(0, 0,      0, 0, 0, 1, 0,  1, 0, 0,      0, 0, 1,  7, 6));
        vq.push_back(mk(0, 0,      0, 0, 0, 0, 0,  0, 0, 0,      0, 0, 0,  7, 6));

        #12;
        check_reset_outputs("reset");
        @(posedge clk);
        #1 reset = 1'b1;

        foreach (vq[i]) begin
            drive(vq[i].br, vq[i].addr, vq[i].lu, vq[i].st, vq[i].ht, vq[i].rs, vq[i].cl);
            check($sformatf("v%0d freeze", i),   32'(o_freeze), 32'(vq[i].e_freeze));
            check($sformatf("v%0d bt", i),       32'(o_bt), 32'(vq[i].e_bt));
            check($sformatf("v%0d addr", i),     32'(o_addr), 32'(vq[i].e_addr));
            check($sformatf("v%0d flush", i),    32'(o_flush), 32'(vq[i].e_flush));
            check($sformatf("v%0d bubble", i),   32'(o_bubble), 32'(vq[i].e_bubble));
            check($sformatf("v%0d halted", i),   32'(o_halted), 32'(vq[i].e_halted));
            check($sformatf("v%0d stallcnt", i), 32'(o_stall_cnt), 32'(vq[i].e_stall));
            check($sformatf("v%0d redircnt", i), 32'(o_redir_cnt), 32'(vq[i].e_redir));
        end

        // Halt held for 10 cycles is frozen but not counted; a branch leaves it.
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            idle();
            check($sformatf("halt%0d freeze", i), 32'(o_freeze), 32'd1);
            check($sformatf("halt%0d halted", i), 32'(o_halted), 32'd1);
        end
        check("halt stallcnt", 32'(o_stall_cnt), 32'd7);
        drive(1'b1, 27'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("halt br bt",     32'(o_bt), 32'd1);
        check("halt br addr",   32'(o_addr), 32'h10);
        check("halt br freeze", 32'(o_freeze), 32'd0);
        idle();
        check("after halt br halted", 32'(o_halted), 32'd0);
        check("after halt br redir",  32'(o_redir_cnt), 32'd7);
        check("after halt br flush",  32'(o_flush), 32'd1);

        // Branch resolving in HALT under a memory stall is held in PEND.
        idle();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 27'h30, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("halt stall br bt",     32'(o_bt), 32'd0);
        check("halt stall br freeze", 32'(o_freeze), 32'd1);
        idle();
        check("pend apply bt",   32'(o_bt), 32'd1);
        check("pend apply addr", 32'(o_addr), 32'h30);
        check("pend apply halted", 32'(o_halted), 32'd0);
        idle();
        check("pend apply stallcnt", 32'(o_stall_cnt), 32'd7);
        check("pend apply redir",    32'(o_redir_cnt), 32'd8);

        // Saturation and clear priority.
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 65540; k++) begin
            drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            if (k == 0) begin
                check("clr stallcnt", 32'(o_stall_cnt), 32'd0);
                check("clr redircnt", 32'(o_redir_cnt), 32'd0);
            end
            if (k == 65534) check("sat-1 stallcnt", 32'(o_stall_cnt), 32'hFFFE);
            if (k == 65535) check("sat stallcnt", 32'(o_stall_cnt), 32'hFFFF);
        end
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("sat hold stallcnt", 32'(o_stall_cnt), 32'hFFFF);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("clr beats inc", 32'(o_stall_cnt), 32'd0);

        // Asynchronous reset while a redirect is held in PEND.
        drive(1'b1, 27'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("pend hold freeze", 32'(o_freeze), 32'd1);
        #2 reset = 1'b0;
        br = 1'b0; stall = 1'b0;
        #1;
        check_reset_outputs("async reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 7; i++) begin
            idle();
            check($sformatf("reboot%0d freeze", i), 32'(o_freeze), (i < 4) ? 32'd1 : 32'd0);
            check($sformatf("reboot%0d bt", i),     32'(o_bt), 32'd0);
            check($sformatf("reboot%0d addr", i),   32'(o_addr), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
